// File: rtl/mux_ctrl_rr.sv
// rtl/mux_ctrl_rr.sv - per-output round-robin mux controller with packet lock and backpressure
// Define MUX_CTRL_PIPELINE_EN to register wr_en_out and mux_sel one cycle behind grant_out.
module mux_ctrl_rr #(
  parameter int PORT_NUB = 4,
  localparam int WIDTH_SEL = (PORT_NUB > 1) ? $clog2(PORT_NUB) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORT_NUB*PORT_NUB-1:0]  port_vaild,
  input  logic [PORT_NUB-1:0]           port_last,
  input  logic [PORT_NUB-1:0]           full_in,
  output logic [PORT_NUB*PORT_NUB-1:0]  grant_out,
  output logic [PORT_NUB-1:0]           wr_en_out,
  output logic [PORT_NUB*WIDTH_SEL-1:0] mux_sel,
  output logic [PORT_NUB-1:0]           busy_out
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} st_t;

  st_t                  st    [PORT_NUB];
  logic [WIDTH_SEL-1:0] ptr   [PORT_NUB];
  logic [WIDTH_SEL-1:0] owner [PORT_NUB];

  // pick: the owner when locked, else the round-robin candidate; acc: its beat is taken this cycle
  logic [WIDTH_SEL-1:0] pick  [PORT_NUB];
  logic                 acc   [PORT_NUB];
  logic                 found [PORT_NUB];
  logic [PORT_NUB-1:0]           wr_c;
  logic [PORT_NUB*WIDTH_SEL-1:0] sel_c;
  int                            idx;

  function automatic logic [WIDTH_SEL-1:0] nxt(input logic [WIDTH_SEL-1:0] j);
    if (int'(j) >= PORT_NUB - 1) return '0;
    return j + WIDTH_SEL'(1);
  endfunction

  always_comb begin
    grant_out = '0;
    wr_c      = '0;
    sel_c     = '0;
    busy_out  = '0;
    idx       = 0;
    for (int i = 0; i < PORT_NUB; i++) begin
      pick[i]  = '0;
      acc[i]   = 1'b0;
      found[i] = 1'b0;
      if (st[i] == LOCK) begin
        pick[i] = owner[i];
        acc[i]  = port_vaild[int'(owner[i])*PORT_NUB + i] & ~full_in[i];
      end else begin
        // descending scan so the requester closest to ptr is the one left in pick
        for (int k = PORT_NUB - 1; k >= 0; k--) begin
          idx = int'(ptr[i]) + k;
          if (idx >= PORT_NUB) idx = idx - PORT_NUB;
          if (port_vaild[idx*PORT_NUB + i]) begin
            pick[i]  = WIDTH_SEL'(idx);
            found[i] = 1'b1;
          end
        end
        acc[i] = found[i] & ~full_in[i];
      end
      if (!rst) begin
        sel_c[i*WIDTH_SEL +: WIDTH_SEL] = pick[i];
        busy_out[i] = (st[i] == LOCK);
        if (acc[i]) begin
          wr_c[i] = 1'b1;
          grant_out[int'(pick[i])*PORT_NUB + i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PORT_NUB; i++) begin
        st[i]    <= IDLE;
        ptr[i]   <= '0;
        owner[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PORT_NUB; i++) begin
        if (acc[i]) begin
          if (port_last[pick[i]]) begin
            st[i]  <= IDLE;
            ptr[i] <= nxt(pick[i]);
          end else begin
            st[i]    <= LOCK;
            owner[i] <= pick[i];
          end
        end
      end
    end
  end

`ifdef MUX_CTRL_PIPELINE_EN
  logic [PORT_NUB-1:0]           wr_q;
  logic [PORT_NUB*WIDTH_SEL-1:0] sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      sel_q <= '0;
    end else begin
      wr_q  <= wr_c;
      sel_q <= sel_c;
    end
  end

  assign wr_en_out = wr_q;
  assign mux_sel   = sel_q;
`else
  assign wr_en_out = wr_c;
  assign mux_sel   = sel_c;
`endif

endmodule

// File: tb/tb_mux_ctrl_rr.sv
// tb/tb_mux_ctrl_rr.sv - bench for mux_ctrl_rr: directed literal cases plus random traffic vs a behavioural model
module tb_mux_ctrl_rr;
  localparam int N = 4;
  localparam int W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [N*N-1:0]   port_vaild;
  logic [N-1:0]     port_last;
  logic [N-1:0]     full_in;
  logic [N*N-1:0]   grant_out;
  logic [N-1:0]     wr_en_out;
  logic [N*W-1:0]   mux_sel;
  logic [N-1:0]     busy_out;

  mux_ctrl_rr #(.PORT_NUB(N)) dut (
    .clk(clk), .rst(rst), .port_vaild(port_vaild), .port_last(port_last), .full_in(full_in),
    .grant_out(grant_out), .wr_en_out(wr_en_out), .mux_sel(mux_sel), .busy_out(busy_out)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: per output a lock flag, owning input and round-robin start point
  int m_lock [N];
  int m_owner[N];
  int m_ptr  [N];
  logic [N-1:0]   prev_wr;
  logic [N*W-1:0] prev_sel;

  initial begin : compare
    logic [N*N-1:0] eg;
    logic [N-1:0]   ew, eb;
    logic [N*W-1:0] es;
    int taken[N];
    int cand;
    for (int i = 0; i < N; i++) begin m_lock[i] = 0; m_owner[i] = 0; m_ptr[i] = 0; end
    prev_wr = '0;
    prev_sel = '0;
    forever begin
      @(negedge clk);
      eg = '0; ew = '0; eb = '0; es = '0;
      for (int i = 0; i < N; i++) begin
        taken[i] = -1;
        if (!rst) begin
          if (m_lock[i] != 0) begin
            eb[i] = 1'b1;
            es[i*W +: W] = W'(m_owner[i]);
            if (port_vaild[m_owner[i]*N + i] && !full_in[i]) taken[i] = m_owner[i];
          end else begin
            cand = -1;
            for (int k = 0; k < N; k++)
              if (cand < 0 && port_vaild[((m_ptr[i] + k) % N)*N + i]) cand = (m_ptr[i] + k) % N;
            if (cand >= 0) es[i*W +: W] = W'(cand);
            if (cand >= 0 && !full_in[i]) taken[i] = cand;
          end
          if (taken[i] >= 0) begin
            ew[i] = 1'b1;
            eg[taken[i]*N + i] = 1'b1;
          end
        end
      end
      chk("grant", 32'(grant_out), 32'(eg));
      chk("busy", 32'(busy_out), 32'(eb));
`ifdef MUX_CTRL_PIPELINE_EN
      chk("wr_en", 32'(wr_en_out), 32'(prev_wr));
      chk("mux_sel", 32'(mux_sel), 32'(prev_sel));
      prev_wr = ew;
      prev_sel = es;
`else
      chk("wr_en", 32'(wr_en_out), 32'(ew));
      chk("mux_sel", 32'(mux_sel), 32'(es));
`endif
      for (int i = 0; i < N; i++) begin
        if (rst) begin
          m_lock[i] = 0; m_owner[i] = 0; m_ptr[i] = 0;
        end else if (taken[i] >= 0) begin
          if (port_last[taken[i]]) begin
            m_lock[i] = 0;
            m_ptr[i] = (taken[i] + 1) % N;
          end else begin
            m_lock[i] = 1;
            m_owner[i] = taken[i];
          end
        end
      end
    end
  end

  task automatic step(input logic r, input logic [N*N-1:0] v, input logic [N-1:0] l, input logic [N-1:0] f);
    @(posedge clk);
    #1;
    rst = r;
    port_vaild = v;
    port_last = l;
    full_in = f;
    #3;
  endtask

  logic [15:0] t3_v [4] = '{16'h0040, 16'h0040, 16'h4040, 16'h4000};
  logic [3:0]  t3_l [4] = '{4'h0, 4'h0, 4'h2, 4'h8};
  logic [15:0] t3_g [4] = '{16'h0040, 16'h0040, 16'h0040, 16'h4000};
  logic        t3_b [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [1:0]  t3_s [4] = '{2'd1, 2'd1, 2'd1, 2'd3};
  logic [15:0] t5_v [4] = '{16'h0080, 16'h0008, 16'h0088, 16'h0008};
  logic [3:0]  t5_l [4] = '{4'h0, 4'h0, 4'h2, 4'h1};
  logic [15:0] t5_g [4] = '{16'h0080, 16'h0000, 16'h0080, 16'h0008};
  logic        t5_b [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic        t5_w [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [1:0]  t5_s [4] = '{2'd1, 2'd1, 2'd1, 2'd0};

  initial begin
    logic [N*N-1:0] v;
    logic [N-1:0]   l, f;
    int o;
    rst = 1'b1;
    port_vaild = '1;
    port_last = '0;
    full_in = '0;

    for (int c = 0; c < 3; c++) step(1'b1, '1, 4'hF, 4'h0);
    chk("rst_grant", 32'(grant_out), 32'h0);
    chk("rst_wr", 32'(wr_en_out), 32'h0);
    chk("rst_sel", 32'(mux_sel), 32'h0);
    chk("rst_busy", 32'(busy_out), 32'h0);

    for (int c = 0; c < 6; c++) begin
      step(1'b0, 16'h0111, 4'hF, 4'h0);
      chk("rr_grant", 32'(grant_out), 32'h1 << (4 * (c % 3)));
`ifndef MUX_CTRL_PIPELINE_EN
      chk("rr_sel", 32'(mux_sel[1:0]), 32'(c % 3));
`endif
    end

    for (int c = 0; c < 4; c++) begin
      step(1'b0, t3_v[c], t3_l[c], 4'h0);
      chk("lock_grant", 32'(grant_out), 32'(t3_g[c]));
      chk("lock_busy", 32'(busy_out[2]), 32'(t3_b[c]));
`ifndef MUX_CTRL_PIPELINE_EN
      chk("lock_sel", 32'(mux_sel[5:4]), 32'(t3_s[c]));
`endif
    end

    for (int c = 0; c < 2; c++) begin
      step(1'b0, 16'h0100, 4'hF, 4'h1);
      chk("full_grant", 32'(grant_out), 32'h0);
`ifndef MUX_CTRL_PIPELINE_EN
      chk("full_wr", 32'(wr_en_out[0]), 32'h0);
`endif
    end
    step(1'b0, 16'h0100, 4'hF, 4'h0);
    chk("full_drop_grant", 32'(grant_out), 32'h0100);

    for (int c = 0; c < 4; c++) begin
      step(1'b0, t5_v[c], t5_l[c], 4'h0);
      chk("bubble_grant", 32'(grant_out), 32'(t5_g[c]));
      chk("bubble_busy", 32'(busy_out[3]), 32'(t5_b[c]));
`ifndef MUX_CTRL_PIPELINE_EN
      chk("bubble_wr", 32'(wr_en_out[3]), 32'(t5_w[c]));
      chk("bubble_sel", 32'(mux_sel[7:6]), 32'(t5_s[c]));
`endif
    end

    step(1'b0, 16'h0802, 4'hF, 4'h0);
    chk("par_grant", 32'(grant_out), 32'h0802);
`ifndef MUX_CTRL_PIPELINE_EN
    chk("par_wr", 32'(wr_en_out), 32'hA);
    chk("par_sel1", 32'(mux_sel[3:2]), 32'h0);
    chk("par_sel3", 32'(mux_sel[7:6]), 32'h2);
`endif
    step(1'b0, 16'h0000, 4'h0, 4'h0);
    chk("par_grant_after", 32'(grant_out), 32'h0);
`ifdef MUX_CTRL_PIPELINE_EN
    chk("par_wr", 32'(wr_en_out), 32'hA);
    chk("par_sel1", 32'(mux_sel[3:2]), 32'h0);
    chk("par_sel3", 32'(mux_sel[7:6]), 32'h2);
`endif

    // random traffic: each input requests at most one output; occasional mid-packet resets
    for (int n = 0; n < 3000; n++) begin
      v = '0;
      for (int j = 0; j < N; j++) begin
        o = $urandom_range(0, 5);
        if (o < N) v[j*N + o] = 1'b1;
        l[j] = ($urandom_range(0, 2) == 0);
        f[j] = ($urandom_range(0, 4) == 0);
      end
      step($urandom_range(0, 199) == 0, v, l, f);
    end
    step(1'b0, '0, '0, '0);
    step(1'b0, '0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
